// File: rtl/explosion_sprite_renderer.sv
// Explosion sprite overlay: lifetime FSM, scan hit test and a 2-clock ROM lookup pipeline.
// Build option: define EXPLOSION_RETRIGGER_EN to let start re-arm an active explosion.
module explosion_sprite_renderer #(
  parameter int unsigned SPRITE_SIZE     = 16,
  parameter int unsigned LIFETIME_FRAMES = 30,
  parameter logic [11:0] TRANSPARENT     = 12'h6CC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  pos_x_in,
  input  logic [9:0]  pos_y_in,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        pixel_valid,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | no explosion on screen, waiting for start
  // ACTIVE | explosion visible, counting frame ticks toward expiry

  localparam int unsigned CNT_W = (LIFETIME_FRAMES > 1) ? $clog2(LIFETIME_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIFETIME_FRAMES - 1);
  localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [9:0]       pos_x_q;
  logic [9:0]       pos_y_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             pixel_valid_q;
  logic [11:0]      rgb_q;

  logic [10:0] x_ext, y_ext, px_ext, py_ext;
  logic        hit;
  logic        pixel_valid_d;
  logic [11:0] rgb_d;

  // One extra bit keeps pos+SIZE from wrapping, so sprites near the right/bottom edge clip.
  always_comb begin
    x_ext  = {1'b0, x};
    y_ext  = {1'b0, y};
    px_ext = {1'b0, pos_x_q};
    py_ext = {1'b0, pos_y_q};
    hit    = busy_q & video_on
           & (x_ext >= px_ext) & (x_ext < px_ext + SIZE11)
           & (y_ext >= py_ext) & (y_ext < py_ext + SIZE11);
  end

  assign rom_col = x[4:0] - pos_x_q[4:0];
  assign rom_row = y[4:0] - pos_y_q[4:0];

  assign pixel_valid_d = hit_q & (rom_data != TRANSPARENT);
  assign rgb_d         = pixel_valid_d ? rom_data : 12'h000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      done_q        <= 1'b0;
      hit_q         <= hit;
      pixel_valid_q <= pixel_valid_d;
      rgb_q         <= rgb_d;
      if (state_q == IDLE) begin
        // A frame_tick in the start cycle is deliberately not counted.
        if (start) begin
          state_q     <= ACTIVE;
          busy_q      <= 1'b1;
          pos_x_q     <= pos_x_in;
          pos_y_q     <= pos_y_in;
          frame_cnt_q <= '0;
        end
      end else begin
`ifdef EXPLOSION_RETRIGGER_EN
        if (start) begin
          pos_x_q     <= pos_x_in;
          pos_y_q     <= pos_y_in;
          frame_cnt_q <= '0;
        end else
`endif
        if (frame_tick) begin
          if (frame_cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            frame_cnt_q <= '0;
          end else begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign rgb_out     = rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_explosion_sprite_renderer.sv
// Directed bench for explosion_sprite_renderer with a 3-frame lifetime and a registered ROM model.
module tb_explosion_sprite_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  pos_x_in, pos_y_in;
  logic        frame_tick;
  logic        video_on;
  logic [9:0]  x, y;
  logic [4:0]  rom_row, rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        pixel_valid, busy, done;

  logic [11:0] rom_color;
  int tests = 0;
  int fails = 0;

  explosion_sprite_renderer #(
    .SPRITE_SIZE(16), .LIFETIME_FRAMES(3), .TRANSPARENT(12'h6CC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .frame_tick(frame_tick), .video_on(video_on), .x(x), .y(y),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .rgb_out(rgb_out), .pixel_valid(pixel_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM: colour keyed on the address so wrong addresses show up in rgb_out.
  always @(posedge clk) rom_data <= rom_color ^ {2'b00, rom_row, rom_col};

  task automatic do_start(input logic [9:0] px, input logic [9:0] py, input logic with_tick,
                          output logic b, output logic d);
    @(negedge clk);
    pos_x_in = px; pos_y_in = py; start = 1'b1; frame_tick = with_tick;
    @(posedge clk); #1;
    b = busy; d = done;
    @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_tick(output logic d, output logic b);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    d = done; b = busy;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic scan(input logic [9:0] sx, input logic [9:0] sy, output logic pv,
                      output logic [11:0] rgb, output logic [4:0] col, output logic [4:0] row);
    @(negedge clk);
    x = sx; y = sy; video_on = 1'b1;
    #1;
    col = rom_col; row = rom_row;
    @(posedge clk);
    @(posedge clk); #1;
    pv = pixel_valid; rgb = rgb_out;
    @(negedge clk);
    video_on = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
    pos_x_in = '0; pos_y_in = '0; x = '0; y = '0; rom_color = 12'hF02;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_pv: got %b want 0", pixel_valid); end
    tests++; if (rgb_out !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hit;
    logic b, d, pv; logic [11:0] rgb; logic [4:0] c, r;
    rom_color = 12'hF02;
    do_start(10'd100, 10'd50, 1'b0, b, d);
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL start_busy: got %b want 1", b); end
    scan(10'd100, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b1) begin fails++; $display("FAIL hit_pv: got %b want 1", pv); end
    tests++; if (rgb !== 12'hF02) begin fails++; $display("FAIL hit_rgb: got %h want F02", rgb); end
    tests++; if (c !== 5'd0 || r !== 5'd0) begin fails++; $display("FAIL hit_addr: got %0d/%0d want 0/0", r, c); end
  endtask

  task automatic test_transparent_bounds;
    logic pv; logic [11:0] rgb; logic [4:0] c, r;
    rom_color = 12'h6CC;
    scan(10'd100, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL key_pv: got %b want 0", pv); end
    tests++; if (rgb !== 12'h000) begin fails++; $display("FAIL key_rgb: got %h want 000", rgb); end
    rom_color = 12'hF02;
    scan(10'd116, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL x_out_pv: got %b want 0", pv); end
    tests++; if (rgb !== 12'h000) begin fails++; $display("FAIL x_out_rgb: got %h want 000", rgb); end
    scan(10'd115, 10'd50, pv, rgb, c, r);
    tests++; if (c !== 5'd15) begin fails++; $display("FAIL x_edge_col: got %0d want 15", c); end
    tests++; if (pv !== 1'b1 || rgb !== 12'hF0D) begin fails++; $display("FAIL x_edge_pix: got %b/%h want 1/F0D", pv, rgb); end
    scan(10'd100, 10'd65, pv, rgb, c, r);
    tests++; if (r !== 5'd15) begin fails++; $display("FAIL y_edge_row: got %0d want 15", r); end
    tests++; if (pv !== 1'b1 || rgb !== 12'hEE2) begin fails++; $display("FAIL y_edge_pix: got %b/%h want 1/EE2", pv, rgb); end
    scan(10'd100, 10'd66, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL y_out_pv: got %b want 0", pv); end
    scan(10'd99, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL x_left_pv: got %b want 0", pv); end
  endtask

  task automatic test_lifetime;
    logic d, b, pv; logic [11:0] rgb; logic [4:0] c, r;
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b1) begin fails++; $display("FAIL life_t1: got done=%b busy=%b want 0/1", d, b); end
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b1) begin fails++; $display("FAIL life_t2: got done=%b busy=%b want 0/1", d, b); end
    do_tick(d, b);
    tests++; if (d !== 1'b1 || b !== 1'b0) begin fails++; $display("FAIL life_t3: got done=%b busy=%b want 1/0", d, b); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_width: got %b want 0", done); end
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b0) begin fails++; $display("FAIL life_t4: got done=%b busy=%b want 0/0", d, b); end
    scan(10'd100, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b0 || rgb !== 12'h000) begin fails++; $display("FAIL idle_pix: got %b/%h want 0/000", pv, rgb); end
  endtask

  task automatic test_clip;
    logic b, d, pv; logic [11:0] rgb; logic [4:0] c, r;
    do_start(10'd1015, 10'd10, 1'b0, b, d);
    scan(10'd1023, 10'd10, pv, rgb, c, r);
    tests++; if (pv !== 1'b1 || rgb !== 12'hF0A) begin fails++; $display("FAIL clip_edge: got %b/%h want 1/F0A", pv, rgb); end
    scan(10'd0, 10'd10, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL clip_wrap: got %b want 0", pv); end
    repeat (3) do_tick(d, b);
    tests++; if (d !== 1'b1 || b !== 1'b0) begin fails++; $display("FAIL clip_end: got done=%b busy=%b want 1/0", d, b); end
  endtask

  task automatic test_start_with_tick;
    logic b, d;
    do_start(10'd100, 10'd50, 1'b1, b, d);
    tests++; if (b !== 1'b1 || d !== 1'b0) begin fails++; $display("FAIL st_tick_start: got busy=%b done=%b want 1/0", b, d); end
    do_tick(d, b);
    tests++; if (d !== 1'b0) begin fails++; $display("FAIL st_tick_t1: got %b want 0", d); end
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b1) begin fails++; $display("FAIL st_tick_t2: got done=%b busy=%b want 0/1", d, b); end
    do_tick(d, b);
    tests++; if (d !== 1'b1 || b !== 1'b0) begin fails++; $display("FAIL st_tick_t3: got done=%b busy=%b want 1/0", d, b); end
  endtask

  task automatic test_retrigger;
    logic b, d, pv; logic [11:0] rgb; logic [4:0] c, r;
    do_start(10'd100, 10'd50, 1'b0, b, d);
    do_tick(d, b);
    do_start(10'd200, 10'd80, 1'b0, b, d);
    tests++; if (b !== 1'b1 || d !== 1'b0) begin fails++; $display("FAIL retrig_start: got busy=%b done=%b want 1/0", b, d); end
    scan(10'd200, 10'd80, pv, rgb, c, r);
`ifdef EXPLOSION_RETRIGGER_EN
    tests++; if (pv !== 1'b1 || rgb !== 12'hF02) begin fails++; $display("FAIL retrig_new: got %b/%h want 1/F02", pv, rgb); end
    scan(10'd100, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL retrig_old: got %b want 0", pv); end
    do_tick(d, b);
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b1) begin fails++; $display("FAIL retrig_cnt2: got done=%b busy=%b want 0/1", d, b); end
    do_tick(d, b);
    tests++; if (d !== 1'b1 || b !== 1'b0) begin fails++; $display("FAIL retrig_cnt3: got done=%b busy=%b want 1/0", d, b); end
`else
    tests++; if (pv !== 1'b0) begin fails++; $display("FAIL ignore_new: got %b want 0", pv); end
    scan(10'd100, 10'd50, pv, rgb, c, r);
    tests++; if (pv !== 1'b1 || rgb !== 12'hF02) begin fails++; $display("FAIL ignore_old: got %b/%h want 1/F02", pv, rgb); end
    do_tick(d, b);
    tests++; if (d !== 1'b0 || b !== 1'b1) begin fails++; $display("FAIL ignore_cnt2: got done=%b busy=%b want 0/1", d, b); end
    do_tick(d, b);
    tests++; if (d !== 1'b1 || b !== 1'b0) begin fails++; $display("FAIL ignore_cnt3: got done=%b busy=%b want 1/0", d, b); end
`endif
    // start landing on the expiring tick
    do_start(10'd100, 10'd50, 1'b0, b, d);
    do_tick(d, b);
    do_tick(d, b);
    do_start(10'd100, 10'd50, 1'b1, b, d);
`ifdef EXPLOSION_RETRIGGER_EN
    tests++; if (b !== 1'b1 || d !== 1'b0) begin fails++; $display("FAIL coinc_retrig: got busy=%b done=%b want 1/0", b, d); end
`else
    tests++; if (b !== 1'b0 || d !== 1'b1) begin fails++; $display("FAIL coinc_drop: got busy=%b done=%b want 0/1", b, d); end
`endif
  endtask

  task automatic test_reset_mid;
    logic b, d;
    rom_color = 12'hF02;
    do_start(10'd100, 10'd50, 1'b0, b, d);
    @(negedge clk);
    x = 10'd100; y = 10'd50; video_on = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_pv: got %b want 1", pixel_valid); end
    reset = 1'b1;
    #1;
    tests++; if (pixel_valid !== 1'b0 || rgb_out !== 12'h000) begin fails++; $display("FAIL mid_rst_pix: got %b/%h want 0/000", pixel_valid, rgb_out); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_rst_ctl: got busy=%b done=%b want 0/0", busy, done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_post_busy: got %b want 0", busy); end
    tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL mid_post_pv: got %b want 0", pixel_valid); end
    @(negedge clk);
    video_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_transparent_bounds();
    test_lifetime();
    test_clip();
    test_start_with_tick();
    test_retrigger();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
